// File: rtl/button_event_ctrl_if.sv
// button_event_ctrl_if: switch level in, gesture pulses and busy flag out.
interface button_event_ctrl_if;
   logic i_switch;
   logic o_short;
   logic o_long;
   logic o_double;
   logic o_busy;
   modport master (input i_switch, output o_short, o_long, o_double, o_busy);
   modport slave  (output i_switch, input o_short, o_long, o_double, o_busy);
endinterface

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: classifies a debounced switch into short/long/double press pulses.
// Define AUTO_REPEAT_EN to re-pulse o_long every REPEAT_LIMIT cycles while a long press is held.
module button_event_ctrl #(
   parameter int LONG_LIMIT   = 25000000,
   parameter int DOUBLE_LIMIT = 7500000,
   parameter int REPEAT_LIMIT = 5000000
) (
   input  logic i_clk,
   input  logic i_rst,
   button_event_ctrl_if.master bus
);
   localparam int MAX_LIMIT = LONG_LIMIT > DOUBLE_LIMIT ? LONG_LIMIT : DOUBLE_LIMIT;
   localparam int CW = $clog2(MAX_LIMIT);

   if (LONG_LIMIT < 2 || DOUBLE_LIMIT < 2 || REPEAT_LIMIT < 2) begin : g_bad_limit
      $error("button_event_ctrl: all limits must be at least 2");
   end

   typedef enum logic [2:0] {IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HOLD} state_t;

   state_t r_state, w_next;
   logic [CW-1:0] r_count;
   logic r_switch, r_short, r_long, r_double, r_busy;
   logic w_press, w_long_lim, w_gap_lim, w_rep_lim, w_short, w_long, w_double;

   assign w_press    = bus.i_switch && !r_switch;
   assign w_long_lim = r_count == CW'(LONG_LIMIT - 1);
   assign w_gap_lim  = r_count == CW'(DOUBLE_LIMIT - 1);

`ifdef AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_LIMIT);
   logic [RW-1:0] r_rep;
   assign w_rep_lim = r_rep == RW'(REPEAT_LIMIT - 1);
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_rep <= '0;
      else r_rep <= (r_state != LONG_HOLD || w_next != LONG_HOLD || w_rep_lim) ? '0 : r_rep + RW'(1);
`else
   assign w_rep_lim = 1'b0;
`endif

   // Release beats the long limit and a second press beats the gap limit.
   always_comb begin
      w_next   = r_state;
      w_short  = 1'b0;
      w_long   = 1'b0;
      w_double = 1'b0;
      case (r_state)
         IDLE:      if (w_press) w_next = PRESS1;
         PRESS1:    if (!bus.i_switch) w_next = WAIT_GAP;
                    else if (w_long_lim) begin
                       w_next = LONG_HOLD;
                       w_long = 1'b1;
                    end
         WAIT_GAP:  if (bus.i_switch) w_next = PRESS2;
                    else if (w_gap_lim) begin
                       w_next  = IDLE;
                       w_short = 1'b1;
                    end
         PRESS2:    if (!bus.i_switch) begin
                       w_next   = IDLE;
                       w_double = 1'b1;
                    end
         LONG_HOLD: if (!bus.i_switch) w_next = IDLE;
                    else w_long = w_rep_lim;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_switch <= 1'b1;
         r_short  <= 1'b0;
         r_long   <= 1'b0;
         r_double <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_count  <= (w_next != r_state || !(r_state inside {PRESS1, WAIT_GAP})) ? '0 : r_count + CW'(1);
         r_switch <= bus.i_switch;
         r_short  <= w_short;
         r_long   <= w_long;
         r_double <= w_double;
         r_busy   <= w_next != IDLE;
      end

   assign bus.o_short  = r_short;
   assign bus.o_long   = r_long;
   assign bus.o_double = r_double;
   assign bus.o_busy   = r_busy;
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: directed gestures; expected pulses queued with their cycle, checked by a monitor.
module tb_button_event_ctrl;
   localparam int LL = 8, DL = 4, RL = 3;
   localparam logic [2:0] EV_S = 3'b001, EV_L = 3'b010, EV_D = 3'b100;

   typedef struct {logic [2:0] ev; int cyc; string name;} exp_t;

   logic clk = 1'b0, rst = 1'b1;
   logic [2:0] obs;
   int cyc = 0, vecs = 0, errs = 0, c;
   exp_t q[$];

   button_event_ctrl_if bus();

   button_event_ctrl #(.LONG_LIMIT(LL), .DOUBLE_LIMIT(DL), .REPEAT_LIMIT(RL)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign obs = {bus.o_double, bus.o_long, bus.o_short};

   always @(negedge clk) begin
      exp_t e;
      if (|obs) begin
         vecs++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL spurious_pulse: got %b at cyc %0d, want no pulse", obs, cyc);
         end else begin
            e = q.pop_front();
            if (obs !== e.ev || cyc != e.cyc) begin
               errs++;
               $display("FAIL %s: got %b at cyc %0d, want %b at cyc %0d", e.name, obs, cyc, e.ev, e.cyc);
            end
         end
      end
   end

   task automatic expect_ev(logic [2:0] ev, int at, string name);
      q.push_back('{ev, at, name});
   endtask

   task automatic hold(logic v, int n);
      bus.i_switch = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(string name, logic got, logic want);
      vecs++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   task automatic drain(string name);
      repeat (12) @(negedge clk);
      vecs++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL %s: %0d expected pulses missing, next %s at cyc %0d", name, q.size(), q[0].name, q[0].cyc);
         q.delete();
      end
   endtask

   initial begin
      bus.i_switch = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", bus.o_busy, 1'b0);
      chk("reset_pulses", |obs, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      // short press, then a double press starting in the pulse cycle
      c = cyc;
      expect_ev(EV_S, c + 8, "short");
      hold(1'b1, 3);
      hold(1'b0, 2);
      chk("short_busy_gap", bus.o_busy, 1'b1);
      hold(1'b0, 3);
      chk("short_busy_idle", bus.o_busy, 1'b0);
      c = cyc;
      expect_ev(EV_D, c + 7, "b2b_double");
      hold(1'b1, 2);
      hold(1'b0, 2);
      hold(1'b1, 2);
      hold(1'b0, 1);
      drain("short_double");
      // long press held 20 cycles
      c = cyc;
      expect_ev(EV_L, c + 9, "long");
`ifdef AUTO_REPEAT_EN
      for (int i = 1; i <= 3; i++) expect_ev(EV_L, c + 9 + i * RL, "long_repeat");
`endif
      hold(1'b1, 20);
      chk("long_busy_held", bus.o_busy, 1'b1);
      hold(1'b0, 1);
      chk("long_busy_released", bus.o_busy, 1'b0);
      drain("long");
      // release sampled when PRESS1 count hits LONG_LIMIT-1
      c = cyc;
      expect_ev(EV_S, c + 13, "race_release");
      hold(1'b1, 8);
      hold(1'b0, 1);
      chk("race_release_busy", bus.o_busy, 1'b1);
      hold(1'b0, 4);
      drain("race_release");
      // press sampled when WAIT_GAP count hits DOUBLE_LIMIT-1
      c = cyc;
      expect_ev(EV_D, c + 9, "race_press");
      hold(1'b1, 2);
      hold(1'b0, 4);
      hold(1'b1, 2);
      hold(1'b0, 1);
      drain("race_press");
      // reset mid-PRESS1 with the switch held through reset
      hold(1'b1, 3);
      rst = 1'b1;
      #1;
      chk("rst_press1_busy", bus.o_busy, 1'b0);
      chk("rst_press1_pulses", |obs, 1'b0);
      hold(1'b1, 3);
      rst = 1'b0;
      hold(1'b1, 10);
      chk("held_through_busy", bus.o_busy, 1'b0);
      hold(1'b0, 3);
      chk("held_release_busy", bus.o_busy, 1'b0);
      drain("held_through");
      c = cyc;
      expect_ev(EV_S, c + 8, "fresh_short");
      hold(1'b1, 3);
      hold(1'b0, 5);
      drain("fresh_short");
      // reset mid-WAIT_GAP
      hold(1'b1, 2);
      hold(1'b0, 2);
      rst = 1'b1;
      #1;
      chk("rst_gap_busy", bus.o_busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      hold(1'b0, 10);
      chk("rst_gap_idle", bus.o_busy, 1'b0);
      drain("rst_gap");
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
